// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive controller.
// Pure declarations: no logic, no latency, no flow control.
package uart_pkg;

    typedef enum logic [1:0] {
        DISABLED = 2'd0,
        ARM      = 2'd1,
        ACTIVE   = 2'd2,
        STOPPING = 2'd3
    } state_t;

    localparam int          ARM_CYCLES    = 2;
    localparam logic [7:0]  FRAME_ERR_MAX = 8'hFF;

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Receiver-side and CPU-read-side signals; master = controller, slave = peers.
// Read data returns one cycle after an accepted rd_req; no backpressure beyond rd_valid.
interface uart_rx_ctrl_if;

    logic       rx_en;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       rx_busy;
    logic       rx_err;
    logic       rd_req;
    logic [7:0] rd_data;
    logic       rd_valid;

    modport master (
        output rx_en,
        input  rx_data,
        input  rx_done,
        input  rx_busy,
        input  rx_err,
        input  rd_req,
        output rd_data,
        output rd_valid
    );

    modport slave (
        input  rx_en,
        output rx_data,
        output rx_done,
        output rx_busy,
        output rx_err,
        output rd_req,
        input  rd_data,
        input  rd_valid
    );

endinterface

// File: rtl/uart_rx_fifo.sv
// Byte FIFO with flush; push visible in count next cycle, pop data registered (1 cycle).
// Full: push dropped (drop=1) unless a same-cycle pop frees the slot; flush discards push/pop.
module uart_rx_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [7:0]    din,
    input  logic          pop,
    input  logic          flush,
    output logic [7:0]    dout,
    output logic          dout_vld,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty,
    output logic          push_ok,
    output logic          pop_ok,
    output logic          drop
);

    localparam int CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign pop_ok  = pop && !empty && !flush;
    assign push_ok = push && !flush && (!full || pop_ok);
    assign drop    = push && !flush && full && !pop_ok;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            dout     <= '0;
            dout_vld <= 1'b0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            dout_vld <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                dout   <= mem[rd_ptr];
                rd_ptr <= rd_ptr + AW'(1);
            end
            dout_vld <= pop_ok;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: enable sequencing, byte FIFO, overrun/frame-error tracking, irq (1-cycle registered).
// Optional idle-timeout interrupt under UART_RX_TIMEOUT_EN; full FIFO drops bytes and sets sticky overrun.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int AW       = 3,
    parameter int STOP_TMO = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_enable,
    input  logic          cfg_flush,
    input  logic          cfg_clr,
    input  logic [AW:0]   cfg_level,
`ifdef UART_RX_TIMEOUT_EN
    input  logic [15:0]   cfg_tmo,
    output logic          timeout_irq,
`endif
    uart_rx_ctrl_if.master bus,
    output logic [AW:0]   fifo_count,
    output logic          fifo_empty,
    output logic          fifo_full,
    output logic          overrun,
    output logic [7:0]    frame_err_cnt,
    output logic          irq
);

    localparam int TW = (STOP_TMO < 1) ? 1 : $clog2(STOP_TMO + 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(STOP_TMO);

    state_t        state;
    state_t        state_nx;
    logic [1:0]    arm_cnt;
    logic [TW-1:0] stop_tmr;
    logic          rx_en_c;
    logic          cap_en;
    logic          err_q;
    logic          push_ok;
    logic          pop_ok;
    logic          drop;
    logic          tmo_term;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= DISABLED;
            arm_cnt  <= '0;
            stop_tmr <= '0;
        end else begin
            state    <= state_nx;
            arm_cnt  <= (state == ARM) ? arm_cnt + 2'd1 : 2'd0;
            stop_tmr <= (state == STOPPING) ? stop_tmr + TW'(1) : '0;
        end
    end

    always_comb begin
        state_nx = state;
        rx_en_c  = 1'b1;
        cap_en   = 1'b0;
        case (state)
            DISABLED: begin
                rx_en_c = 1'b0;
                if (cfg_enable) state_nx = ARM;
            end
            ARM: begin
                if (!cfg_enable)
                    state_nx = DISABLED;
                else if (arm_cnt == 2'(ARM_CYCLES - 1))
                    state_nx = ACTIVE;
            end
            ACTIVE: begin
                cap_en = 1'b1;
                if (!cfg_enable) state_nx = STOPPING;
            end
            STOPPING: begin
                // Re-enable wins over exit so a quick toggle never drops the receiver.
                cap_en = 1'b1;
                if (cfg_enable)
                    state_nx = ACTIVE;
                else if (!bus.rx_busy || stop_tmr == TMO_MAX)
                    state_nx = DISABLED;
            end
            default: begin
                state_nx = DISABLED;
                rx_en_c  = 1'b0;
            end
        endcase
    end

    assign bus.rx_en = rx_en_c;

    uart_rx_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (bus.rx_done && cap_en),
        .din      (bus.rx_data),
        .pop      (bus.rd_req),
        .flush    (cfg_flush),
        .dout     (bus.rd_data),
        .dout_vld (bus.rd_valid),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .push_ok  (push_ok),
        .pop_ok   (pop_ok),
        .drop     (drop)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q         <= 1'b0;
            overrun       <= 1'b0;
            frame_err_cnt <= '0;
        end else begin
            err_q <= bus.rx_err;
            if (cfg_clr) begin
                overrun       <= 1'b0;
                frame_err_cnt <= '0;
            end else begin
                if (drop)
                    overrun <= 1'b1;
                if (bus.rx_err && !err_q && frame_err_cnt != FRAME_ERR_MAX)
                    frame_err_cnt <= frame_err_cnt + 8'd1;
            end
        end
    end

`ifdef UART_RX_TIMEOUT_EN
    logic [15:0] idle_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt    <= '0;
            timeout_irq <= 1'b0;
        end else begin
            if (push_ok || pop_ok || cfg_flush)
                idle_cnt <= '0;
            else if (!fifo_empty && !bus.rx_busy && idle_cnt != 16'hFFFF)
                idle_cnt <= idle_cnt + 16'd1;

            if (pop_ok || cfg_flush)
                timeout_irq <= 1'b0;
            else if (cfg_tmo != 16'd0 && idle_cnt == cfg_tmo)
                timeout_irq <= 1'b1;
        end
    end

    assign tmo_term = timeout_irq;
`else
    logic unused_ok;
    assign unused_ok = push_ok;
    assign tmo_term  = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            irq <= 1'b0;
        else
            irq <= overrun || (cfg_level != '0 && fifo_count >= cfg_level) || tmo_term;
    end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Controller sitting between the 8-bit UART receiver and the APB register slave. Sequences the receiver enable, captures completed bytes into a small receive FIFO, and tracks overrun and frame errors. Serves CPU-side reads with a simple request/valid handshake and raises a level-triggered interrupt. All logic is single-clock. The receiver's one-cycle done/err indications are consumed directly on clk.

Parameters:
DEPTH, 8, receive FIFO entries; power of two, 2..256
AW, 3, log2(DEPTH); count ports are AW+1 bits
STOP_TMO, 255, max cycles in STOPPING waiting for the receiver to go idle before forced disable

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
cfg_enable  in  1  software receive enable (level)
cfg_flush  in  1  one-cycle pulse: empty FIFO
cfg_clr  in  1  one-cycle pulse: clear overrun flag and frame error counter
cfg_level  in  AW+1  interrupt threshold; 0 disables the level interrupt
rx_en  out  1  enable to receiver
rx_data  in  8  receiver output byte
rx_done  in  1  receiver byte-complete pulse
rx_busy  in  1  receiver frame in progress
rx_err  in  1  receiver error flag
rd_req  in  1  pop request from register slave
rd_data  out  8  popped byte
rd_valid  out  1  rd_data valid, one-cycle pulse
fifo_count  out  AW+1  current occupancy
fifo_empty  out  1  count==0
fifo_full  out  1  count==DEPTH
overrun  out  1  sticky: byte dropped because FIFO full
frame_err_cnt  out  8  saturating count of rx_err rising edges
irq  out  1  interrupt

Behaviour:
- Reset (async, rst=1): state DISABLED, rx_en=0, FIFO empty, rd_data=0, rd_valid=0, overrun=0, frame_err_cnt=0, irq=0, STOPPING timer=0.
- FSM:
  - DISABLED: rx_en=0; cfg_enable=1 -> ARM.
  - ARM: rx_en=1 for exactly 2 cycles, letting the receiver pass through its reset state; captures ignored; -> ACTIVE. If cfg_enable drops during ARM -> DISABLED.
  - ACTIVE: rx_en=1; captures enabled; cfg_enable=0 -> STOPPING.
  - STOPPING: rx_en=1, captures enabled. Exit -> DISABLED when rx_busy=0, or when the timer reaches STOP_TMO. A byte whose rx_done arrives in the exit cycle is still captured. cfg_enable=1 in STOPPING -> ACTIVE.
- Capture: rx_done=1 while captures are enabled pushes rx_data the same cycle; it is visible in fifo_count the next cycle.
  - FIFO full: byte dropped, overrun<=1.
  - rx_done outside ACTIVE/STOPPING: ignored.
- Frame error: rising edge of rx_err (registered previous value) increments frame_err_cnt; saturates at 255.
- Read: rd_req=1 with FIFO non-empty pops the head; rd_data registered, rd_valid=1 next cycle. rd_req on empty: no pop, rd_valid stays 0, rd_data holds.
- Simultaneous push and pop: both occur, count unchanged. When full, a simultaneous pop frees a slot, so the push succeeds and no overrun is set.
- cfg_flush: count=0, pointers=0. A same-cycle push or pop is discarded; overrun is unaffected.
- cfg_clr has priority over a same-cycle overrun set or counter increment: the result is cleared.
- irq = overrun | (cfg_level!=0 && fifo_count>=cfg_level) [| timeout_irq]; registered, 1-cycle latency.
- Pointer wrap modulo DEPTH; full/empty derived from an AW+1-bit count.

Optional Feature:
Macro UART_RX_TIMEOUT_EN.
- Defined: adds input cfg_tmo[15:0] and output timeout_irq (sticky).
  - An idle counter reloads on every push, pop, or flush, and counts while the FIFO is non-empty and rx_busy=0.
  - On reaching cfg_tmo (nonzero), timeout_irq<=1; it is cleared by a pop or a flush.
  - timeout_irq is ORed into irq.
- Undefined: no port, no counter; irq excludes the term.

Decomposition:
- Package uart_pkg:
  - FSM state enum (DISABLED, ARM, ACTIVE, STOPPING)
  - ARM_CYCLES=2
  - FRAME_ERR_MAX=8'hFF
- Sub-module uart_rx_fifo: sync FIFO with push, pop, flush, count, and registered read data. The FSM, error tracking and irq stay in uart_rx_ctrl.

Test Plan:
- Bring-up: rst pulse, then cfg_enable=1 -> rx_en=1 one cycle later; a rx_done at the 1st ARM cycle is not captured; rx_done with 0xA5 in ACTIVE -> fifo_count=1; rd_req -> rd_valid with rd_data=0xA5 next cycle.
- Full/overrun: DEPTH=8, push 9 bytes 0x00..0x08 -> fifo_full=1, overrun=1, irq=1; reads return 0x00..0x07; cfg_clr -> overrun=0.
- Push+pop while full: push and pop in the same cycle -> count stays 8, overrun stays 0, the new byte is read last.
- Threshold irq: cfg_level=3 -> irq rises the cycle after the 3rd push and falls after a pop to count 2.
- Graceful stop:
  - cfg_enable=0 with rx_busy=1 -> rx_en held; a rx_done in STOPPING is captured; rx_busy=0 -> rx_en=0 next cycle.
  - rx_busy stuck at 1 -> forced disable after 255 cycles.
- Errors and reset: 300 rx_err rising edges -> frame_err_cnt=255; rst asserted mid-frame -> rx_en=0, FIFO empty, counters zero immediately (asynchronously).
